// File: rtl/vector_cache_pkg.sv
// Shared constants and types for the vector-cache SRAM bank group.
// Defaults describe the four-direction, eight-bank configuration.
package vector_cache_pkg;

  localparam int DEF_NUM_BANK = 8;
  localparam int DEF_NUM_SRC  = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_RD_LAT   = 2;

  typedef enum logic [1:0] {
    SRC_LEFT  = 2'd0,
    SRC_RIGHT = 2'd1,
    SRC_UP    = 2'd2,
    SRC_DOWN  = 2'd3
  } src_id_e;

  typedef struct packed {
    logic                          wr;
    logic [$clog2(DEF_NUM_BANK)-1:0] bank;
    logic [DEF_ADDR_W-1:0]         addr;
    logic [DEF_DATA_W-1:0]         wdata;
    logic [DEF_DATA_W/8-1:0]       be;
  } req_t;

  // Index width that stays legal for a single-entry range.
  function automatic int clog2_min1(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr and
// returns the pointer to use next cycle (one past the winner, else unchanged).
module rr_arbiter
  import vector_cache_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr_nxt
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = PW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        ptr_nxt      = PW'((int'(cand) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/sram_bank_arb_group.sv
// Addressed, per-bank round-robin access from directional sources to
// single-port banks, with a fixed-latency read return to the requester.
module sram_bank_arb_group
  import vector_cache_pkg::*;
#(
  parameter  int NUM_BANK = DEF_NUM_BANK,
  parameter  int NUM_SRC  = DEF_NUM_SRC,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int RD_LAT   = DEF_RD_LAT,
  localparam int BANK_W   = clog2_min1(NUM_BANK),
  localparam int SRC_W    = clog2_min1(NUM_SRC),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              req_vld,
  output logic [NUM_SRC-1:0]              req_rdy,
  input  logic [NUM_SRC-1:0]              req_wr,
  input  logic [NUM_SRC-1:0][BANK_W-1:0]  req_bank,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]  req_wdata,
  input  logic [NUM_SRC-1:0][BE_W-1:0]    req_be,
  output logic [NUM_SRC-1:0]              rsp_vld,
  output logic [NUM_SRC-1:0][DATA_W-1:0]  rsp_data
);

  logic [NUM_SRC-1:0] bank_gnt [NUM_BANK];
  logic               out_vld  [NUM_BANK];
  logic [SRC_W-1:0]   out_src  [NUM_BANK];
  logic [DATA_W-1:0]  out_data [NUM_BANK];

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [NUM_SRC-1:0] breq;
    logic [NUM_SRC-1:0] gnt;
    logic [SRC_W-1:0]   ptr_q;
    logic [SRC_W-1:0]   ptr_d;
    logic               sel_vld;
    logic               sel_wr;
    logic [SRC_W-1:0]   sel_src;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  mem [2**ADDR_W];
    logic [RD_LAT-1:0]              pipe_vld;
    logic [RD_LAT-1:0][SRC_W-1:0]   pipe_src;
    logic [RD_LAT-1:0][DATA_W-1:0]  pipe_data;

    always_comb begin
      breq = '0;
      for (int s = 0; s < NUM_SRC; s++)
        breq[s] = req_vld[s] && (req_bank[s] == BANK_W'(b));
    end

    rr_arbiter #(.N(NUM_SRC)) u_arb (
      .req     (breq),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .ptr_nxt (ptr_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
    end

    // gnt is one-hot, so the OR-free priority mux reduces to a plain select.
    always_comb begin
      sel_wr    = 1'b0;
      sel_src   = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (gnt[s]) begin
          sel_wr    = req_wr[s];
          sel_src   = SRC_W'(s);
          sel_addr  = req_addr[s];
          sel_wdata = req_wdata[s];
          sel_be    = req_be[s];
        end
      end
    end

    assign sel_vld = |gnt;

    // Behavioural storage; not reset, stands in for an SRAM macro.
    always_ff @(posedge clk) begin
      if (sel_vld && sel_wr) begin
        for (int j = 0; j < BE_W; j++)
          if (sel_be[j]) mem[sel_addr][8*j +: 8] <= sel_wdata[8*j +: 8];
      end
    end

    assign rd_word = mem[sel_addr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_vld  <= '0;
        pipe_src  <= '0;
        pipe_data <= '0;
      end else begin
        pipe_vld[0]  <= sel_vld && !sel_wr;
        pipe_src[0]  <= sel_src;
        pipe_data[0] <= rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
          pipe_vld[i]  <= pipe_vld[i-1];
          pipe_src[i]  <= pipe_src[i-1];
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end

    assign bank_gnt[b] = gnt;
    assign out_vld[b]  = pipe_vld[RD_LAT-1];
    assign out_src[b]  = pipe_src[RD_LAT-1];
    assign out_data[b] = pipe_data[RD_LAT-1];
  end

  // Each source targets one bank per cycle, so at most one grant and one
  // returning read land on any source port.
  always_comb begin
    req_rdy = '0;
    for (int b = 0; b < NUM_BANK; b++)
      req_rdy = req_rdy | bank_gnt[b];
  end

  always_comb begin
    rsp_vld  = '0;
    rsp_data = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (out_vld[b] && (out_src[b] == SRC_W'(s))) begin
          rsp_vld[s]  = 1'b1;
          rsp_data[s] = out_data[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bank_arb_group.sv
// Scoreboard bench: a word-level memory model and round-robin pointer model
// predict grants and read responses; a monitor pops and compares responses.
module tb_sram_bank_arb_group;

  localparam int NS  = 4;
  localparam int NB  = 8;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int RL  = 2;
  localparam int BW  = 3;
  localparam int BEW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0]          req_vld = '0;
  logic [NS-1:0]          req_wr  = '0;
  logic [NS-1:0][BW-1:0]  req_bank = '0;
  logic [NS-1:0][AW-1:0]  req_addr = '0;
  logic [NS-1:0][DW-1:0]  req_wdata = '0;
  logic [NS-1:0][BEW-1:0] req_be = '0;
  logic [NS-1:0]          req_rdy;
  logic [NS-1:0]          rsp_vld;
  logic [NS-1:0][DW-1:0]  rsp_data;

  sram_bank_arb_group u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_vld(rsp_vld), .rsp_data(rsp_data)
  );

  logic [1:0]        sw_vld = '0;
  logic [1:0]        sw_wr  = '0;
  logic [1:0][1:0]   sw_bank = '0;
  logic [1:0][9:0]   sw_addr = '0;
  logic [1:0][63:0]  sw_wdata = '0;
  logic [1:0][7:0]   sw_be = '0;
  logic [1:0]        sw_rdy;
  logic [1:0]        sw_rsp_vld;
  logic [1:0][63:0]  sw_rsp_data;

  sram_bank_arb_group #(.NUM_BANK(4), .NUM_SRC(2), .DATA_W(64), .ADDR_W(10), .RD_LAT(1)) u_sw (
    .clk(clk), .rst_n(rst_n),
    .req_vld(sw_vld), .req_rdy(sw_rdy), .req_wr(sw_wr),
    .req_bank(sw_bank), .req_addr(sw_addr), .req_wdata(sw_wdata),
    .req_be(sw_be), .rsp_vld(sw_rsp_vld), .rsp_data(sw_rsp_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          src;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int            m_ptr [NB];
  logic [DW-1:0] m_mem [NB][2**AW];
  logic [NS-1:0] dut_rdy;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One cycle: sample grants mid-cycle, update the model, return after the edge.
  task automatic step(output logic [NS-1:0] acc);
    logic [NS-1:0] e_rdy;
    bit            found;
    int            s;
    exp_t          e;
    @(negedge clk);
    dut_rdy = req_rdy;
    e_rdy = '0;
    for (int b = 0; b < NB; b++) begin
      found = 0;
      for (int i = 0; i < NS; i++) begin
        s = (m_ptr[b] + i) % NS;
        if (!found && req_vld[s] && int'(req_bank[s]) == b) begin
          found    = 1;
          e_rdy[s] = 1'b1;
          m_ptr[b] = (s + 1) % NS;
        end
      end
    end
    chk("req_rdy", 64'(dut_rdy), 64'(e_rdy));
    acc = req_vld & e_rdy;
    for (int k = 0; k < NS; k++) begin
      if (acc[k] && !req_wr[k]) begin
        e.due  = cyc + RL;
        e.src  = k;
        e.data = m_mem[req_bank[k]][req_addr[k]];
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < NS; k++) begin
      if (acc[k] && req_wr[k])
        for (int j = 0; j < BEW; j++)
          if (req_be[k][j]) m_mem[req_bank[k]][req_addr[k]][8*j +: 8] = req_wdata[k][8*j +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int s, logic wr, int b, int a, logic [DW-1:0] d, logic [BEW-1:0] be);
    req_vld[s]   = 1'b1;
    req_wr[s]    = wr;
    req_bank[s]  = BW'(b);
    req_addr[s]  = AW'(a);
    req_wdata[s] = d;
    req_be[s]    = be;
  endtask

  task automatic issue(int s, logic wr, int b, int a, logic [DW-1:0] d, logic [BEW-1:0] be);
    logic [NS-1:0] acc;
    int n;
    set_req(s, wr, b, a, d, be);
    n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc[s] && n < 20);
    if (!acc[s]) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: src %0d not accepted in %0d cycles", s, n);
    end
    req_vld[s] = 1'b0;
  endtask

  task automatic new_rand(int s, bit hot);
    if ($urandom_range(0, 3) == 0) req_vld[s] = 1'b0;
    else set_req(s, 1'($urandom_range(0, 1)),
                 hot ? int'($urandom_range(0, 1)) : int'($urandom_range(0, NB-1)),
                 int'($urandom_range(0, 3)), $urandom, BEW'($urandom_range(0, 15)));
  endtask

  task automatic idle(int n);
    logic [NS-1:0] acc;
    req_vld = '0;
    repeat (n) step(acc);
  endtask

  // Response monitor: pairs each rsp_vld with the oldest expectation of that source.
  initial begin
    forever begin
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].src == s) idx = i;
        if (rsp_vld[s]) begin
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: src %0d got data %h, required no response", s, rsp_data[s]);
          end else begin
            chk("rsp_cycle", 64'(cyc), 64'(exp_q[idx].due));
            chk("rsp_data", 64'(rsp_data[s]), 64'(exp_q[idx].data));
            exp_q.delete(idx);
          end
        end else if (idx >= 0 && exp_q[idx].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL rsp_missing: src %0d got no response, required data %h at cycle %0d",
                   s, exp_q[idx].data, exp_q[idx].due);
          exp_q.delete(idx);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NS-1:0] acc;
    int            cnt [NS];
    logic [63:0]   sw_val;
    logic [1:0]    sw_e;
    int            g;
    int            prev;

    for (int b = 0; b < NB; b++) m_ptr[b] = 0;

    @(negedge clk);
    chk("reset_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_req_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write then read
    issue(0, 1'b1, 3, 5, 32'hDEADBEEF, 4'hF);
    issue(0, 1'b0, 3, 5, '0, '0);
    idle(3);

    // Byte-lane merge
    issue(0, 1'b1, 1, 7, 32'h11223344, 4'hF);
    issue(0, 1'b1, 1, 7, 32'hAABBCCDD, 4'b0101);
    issue(2, 1'b0, 1, 7, '0, '0);
    idle(3);

    // Four sources on four banks in parallel
    for (int b = 0; b < 4; b++) issue(0, 1'b1, b, 9, 32'hC0DE0000 + 32'(b), 4'hF);
    for (int s = 0; s < NS; s++) set_req(s, 1'b0, s, 9, '0, '0);
    step(acc);
    chk("parallel_rdy", 64'(dut_rdy), 64'hF);
    idle(3);

    // Fill the random working set so every read hits defined storage
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 4; a++) issue(0, 1'b1, b, a, $urandom, 4'hF);

    for (int s = 0; s < NS; s++) new_rand(s, 1'b1);
    for (int c = 0; c < 400; c++) begin
      step(acc);
      for (int s = 0; s < NS; s++)
        if (acc[s] || !req_vld[s]) new_rand(s, c < 200);
    end
    idle(4);

    // Reset with a read in flight: its response must vanish, storage survives
    issue(1, 1'b0, 2, 0, '0, '0);
    rst_n = 1'b0;
    exp_q.delete();
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
    @(negedge clk);
    chk("midrst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("midrst_req_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    issue(2, 1'b0, 3, 5, '0, '0);

    // Full contention on bank 0
    for (int s = 0; s < NS; s++) begin
      set_req(s, 1'b0, 0, 1, '0, '0);
      cnt[s] = 0;
    end
    for (int c = 0; c < 12; c++) begin
      step(acc);
      for (int s = 0; s < NS; s++) if (dut_rdy[s]) cnt[s]++;
    end
    for (int s = 0; s < NS; s++) chk("contention_grants", 64'(cnt[s]), 64'd3);
    idle(4);

    // Two-source, four-bank, 64-bit, single-cycle-latency instance
    sw_val = 64'h0123_4567_89AB_CDEF;
    sw_vld[0] = 1'b1; sw_wr[0] = 1'b1; sw_bank[0] = 2'd2; sw_addr[0] = 10'd1;
    sw_wdata[0] = sw_val; sw_be[0] = '1;
    @(negedge clk);
    chk("sw_write_rdy", 64'(sw_rdy), 64'h1);
    @(posedge clk);
    #1;
    sw_vld = 2'b11; sw_wr = '0;
    sw_bank[1] = 2'd2; sw_addr[1] = 10'd1;
    g = 1;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sw_e = '0;
      sw_e[g] = 1'b1;
      chk("sw_rdy", 64'(sw_rdy), 64'(sw_e));
      if (prev < 0) chk("sw_rsp_vld", 64'(sw_rsp_vld), 64'd0);
      else begin
        sw_e = '0;
        sw_e[prev] = 1'b1;
        chk("sw_rsp_vld", 64'(sw_rsp_vld), 64'(sw_e));
        chk("sw_rsp_data", sw_rsp_data[prev], sw_val);
      end
      prev = g;
      g = 1 - g;
      @(posedge clk);
      #1;
    end
    sw_vld = '0;
    @(negedge clk);
    sw_e = '0;
    sw_e[prev] = 1'b1;
    chk("sw_last_rsp_vld", 64'(sw_rsp_vld), 64'(sw_e));
    chk("sw_last_rsp_data", sw_rsp_data[prev], sw_val);

    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
